// File: rtl/axis_msg_arbiter.sv
// Round-robin arbiter funnelling NUM_SRC AXI-Stream sources into one msg_parser input.
// Packets are locked to one source until tlast; overlong packets are truncated and drained.
module axis_msg_arbiter #(
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned DATA_BYTES = 8,
    parameter int unsigned MAX_BEATS  = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_SRC-1:0]                 s_tvalid,
    output logic [NUM_SRC-1:0]                 s_tready,
    input  logic [NUM_SRC-1:0]                 s_tlast,
    input  logic [NUM_SRC*8*DATA_BYTES-1:0]    s_tdata,
    input  logic [NUM_SRC*DATA_BYTES-1:0]      s_tkeep,
    input  logic [NUM_SRC-1:0]                 s_tuser,
    output logic                               m_tvalid,
    input  logic                               m_tready,
    output logic                               m_tlast,
    output logic                               m_tuser,
    output logic [8*DATA_BYTES-1:0]            m_tdata,
    output logic [DATA_BYTES-1:0]              m_tkeep,
    output logic                               grant_valid,
    output logic [$clog2(NUM_SRC)-1:0]         grant_id,
    output logic                               trunc_err
);

    localparam int unsigned DW    = 8 * DATA_BYTES;
    localparam int unsigned ID_W  = $clog2(NUM_SRC);
    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_BEATS - 1);

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DRAIN
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ID_W-1:0]   last_grant;
    logic [ID_W-1:0]   last_grant_nxt;
    logic [ID_W-1:0]   grant_nxt;
    logic [CNT_W-1:0]  beat_cnt;
    logic [CNT_W-1:0]  beat_cnt_nxt;
    logic [ID_W-1:0]   rr_pick;
    logic              at_limit;

    // Lowest-distance requester above base wins; scanning downward leaves the nearest one.
    function automatic logic [ID_W-1:0] rr_next(input logic [ID_W-1:0] base,
                                                 input logic [NUM_SRC-1:0] req);
        logic [ID_W-1:0] pick;
        logic [ID_W-1:0] idx;
        pick = base;
        for (int i = int'(NUM_SRC); i >= 1; i--) begin
            idx = ID_W'((32'(base) + 32'(i)) % NUM_SRC);
            if (req[idx]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

    assign rr_pick     = rr_next(last_grant, s_tvalid);
    assign at_limit    = (beat_cnt == LAST_IDX);
    assign grant_valid = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            grant_id   <= '0;
            last_grant <= ID_W'(NUM_SRC - 1);
            beat_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            grant_id   <= grant_nxt;
            last_grant <= last_grant_nxt;
            beat_cnt   <= beat_cnt_nxt;
        end
    end

    // Zero-latency pass-through of the granted source plus next-state selection.
    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant_id;
        last_grant_nxt = last_grant;
        beat_cnt_nxt   = beat_cnt;
        s_tready       = '0;
        m_tvalid       = 1'b0;
        m_tlast        = 1'b0;
        m_tuser        = 1'b0;
        trunc_err      = 1'b0;
        m_tdata        = s_tdata[grant_id*DW +: DW];
        m_tkeep        = s_tkeep[grant_id*DATA_BYTES +: DATA_BYTES];

        case (state)
            IDLE: begin
                beat_cnt_nxt = '0;
                if (|s_tvalid) begin
                    grant_nxt      = rr_pick;
                    last_grant_nxt = rr_pick;
                    state_nxt      = XFER;
                end
            end
            XFER: begin
                m_tvalid           = s_tvalid[grant_id];
                s_tready[grant_id] = m_tready;
                // The limit beat is forced to close the packet and flag it as errored.
                m_tlast            = s_tlast[grant_id] | at_limit;
                m_tuser            = s_tuser[grant_id] | (at_limit & ~s_tlast[grant_id]);
                if (m_tvalid && m_tready) begin
                    beat_cnt_nxt = beat_cnt + CNT_W'(1);
                    if (at_limit && !s_tlast[grant_id]) begin
                        trunc_err = 1'b1;
                        state_nxt = DRAIN;
                    end else if (s_tlast[grant_id]) begin
                        state_nxt = IDLE;
                    end
                end
            end
            DRAIN: begin
                s_tready[grant_id] = 1'b1;
                if (s_tvalid[grant_id] && s_tlast[grant_id]) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_axis_msg_arbiter.sv
// Scoreboard bench for axis_msg_arbiter: per-source packet queues feed the DUT and
// expected master beats are queued in grant order when the packets are created.
module tb_axis_msg_arbiter;

    localparam int NUM_SRC    = 4;
    localparam int DATA_BYTES = 8;
    localparam int MAX_BEATS  = 4;
    localparam int DW         = 8 * DATA_BYTES;
    localparam int ID_W       = 2;

    typedef struct packed {
        logic [DW-1:0]         data;
        logic [DATA_BYTES-1:0] keep;
        logic                  last;
        logic                  user;
        logic                  first;
    } beat_t;

    typedef struct packed {
        logic [DW-1:0]         data;
        logic [DATA_BYTES-1:0] keep;
        logic                  last;
        logic                  user;
        logic [ID_W-1:0]       src;
    } exp_t;

    logic                          clk = 1'b0;
    logic                          rst;
    logic [NUM_SRC-1:0]            s_tvalid;
    logic [NUM_SRC-1:0]            s_tready;
    logic [NUM_SRC-1:0]            s_tlast;
    logic [NUM_SRC*DW-1:0]         s_tdata;
    logic [NUM_SRC*DATA_BYTES-1:0] s_tkeep;
    logic [NUM_SRC-1:0]            s_tuser;
    logic                          m_tvalid;
    logic                          m_tready;
    logic                          m_tlast;
    logic                          m_tuser;
    logic [DW-1:0]                 m_tdata;
    logic [DATA_BYTES-1:0]         m_tkeep;
    logic                          grant_valid;
    logic [ID_W-1:0]               grant_id;
    logic                          trunc_err;

    beat_t src_q[NUM_SRC][$];
    exp_t  sb[$];
    int    grant_log[$];
    int    gap_log[$];
    int    checks = 0;
    int    errors = 0;
    int    trunc_cnt = 0;
    int    exp_trunc = 0;
    int    out_cnt = 0;
    int    hold_cnt = 0;
    int    idle_run = 0;
    int    cyc = 0;
    int    ready_mode = 0;
    logic  gaps_on = 1'b0;
    logic  prev_stall = 1'b0;
    logic  prev_gv = 1'b0;
    logic [ID_W-1:0] prev_gid = '0;
    logic [DW+DATA_BYTES+ID_W+2:0] prev_out = '0;

    axis_msg_arbiter #(
        .NUM_SRC(NUM_SRC),
        .DATA_BYTES(DATA_BYTES),
        .MAX_BEATS(MAX_BEATS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s_tvalid(s_tvalid),
        .s_tready(s_tready),
        .s_tlast(s_tlast),
        .s_tdata(s_tdata),
        .s_tkeep(s_tkeep),
        .s_tuser(s_tuser),
        .m_tvalid(m_tvalid),
        .m_tready(m_tready),
        .m_tlast(m_tlast),
        .m_tuser(m_tuser),
        .m_tdata(m_tdata),
        .m_tkeep(m_tkeep),
        .grant_valid(grant_valid),
        .grant_id(grant_id),
        .trunc_err(trunc_err)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Queue a packet on a source and the master beats it must produce.
    task automatic add_pkt(input int src, input int nbeats, input logic user_last);
        beat_t b;
        exp_t  e;
        int    n_out;
        n_out = (nbeats < MAX_BEATS) ? nbeats : MAX_BEATS;
        for (int k = 0; k < nbeats; k++) begin
            b.data  = {$urandom, $urandom};
            b.keep  = 8'($urandom);
            b.last  = (k == nbeats - 1);
            b.user  = b.last & user_last;
            b.first = (k == 0);
            src_q[src].push_back(b);
            if (k < n_out) begin
                e.data = b.data;
                e.keep = b.keep;
                e.src  = ID_W'(src);
                if (k == n_out - 1 && nbeats > MAX_BEATS) begin
                    e.last = 1'b1;
                    e.user = 1'b1;
                end else begin
                    e.last = b.last;
                    e.user = b.user;
                end
                sb.push_back(e);
            end
        end
        if (nbeats > MAX_BEATS) exp_trunc++;
    endtask

    task automatic drive_src(input int i, input logic accepted);
        beat_t b;
        logic  held;
        if (accepted) b = src_q[i].pop_front();
        held = s_tvalid[i] && !accepted;
        if (src_q[i].size() == 0) begin
            s_tvalid[i] = 1'b0;
        end else if (!held && gaps_on && !src_q[i][0].first && $urandom_range(0, 2) == 0) begin
            s_tvalid[i] = 1'b0;
        end else begin
            s_tvalid[i]                         = 1'b1;
            s_tdata[i*DW +: DW]                 = src_q[i][0].data;
            s_tkeep[i*DATA_BYTES +: DATA_BYTES] = src_q[i][0].keep;
            s_tlast[i]                          = src_q[i][0].last;
            s_tuser[i]                          = src_q[i][0].user;
        end
    endtask

    // One clock: monitor/scoreboard at the falling edge, source and sink drive after the rising edge.
    task automatic step_cycle();
        logic [NUM_SRC-1:0] acc;
        logic [NUM_SRC-1:0] mask;
        exp_t e;
        @(negedge clk);
        mask = grant_valid ? (NUM_SRC'(1) << grant_id) : '0;
        checks++;
        if ((s_tready & ~mask) !== '0) begin
            errors++;
            $display("FAIL s_tready_owner: got s_tready=%b with grant_valid=%b grant_id=%0d",
                     s_tready, grant_valid, grant_id);
        end
        checks++;
        if (m_tvalid && !grant_valid) begin
            errors++;
            $display("FAIL m_tvalid_no_grant: got m_tvalid=1 while grant_valid=0");
        end
        if (m_tvalid && m_tready) begin
            out_cnt++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat: got data=%h from src %0d, expected no beat",
                         m_tdata, grant_id);
            end else begin
                e = sb.pop_front();
                if ({m_tdata, m_tkeep, m_tlast, m_tuser, grant_id} !== {e.data, e.keep, e.last, e.user, e.src}) begin
                    errors++;
                    $display("FAIL beat: got data=%h keep=%h last=%b user=%b src=%0d, expected data=%h keep=%h last=%b user=%b src=%0d",
                             m_tdata, m_tkeep, m_tlast, m_tuser, grant_id, e.data, e.keep, e.last, e.user, e.src);
                end
            end
        end
        if (trunc_err) begin
            trunc_cnt++;
            checks++;
            if (!(m_tvalid && m_tready && m_tlast && m_tuser)) begin
                errors++;
                $display("FAIL trunc_err_beat: got trunc_err=1 with valid=%b ready=%b last=%b user=%b, expected all 1",
                         m_tvalid, m_tready, m_tlast, m_tuser);
            end
        end
        if (prev_stall) begin
            hold_cnt++;
            checks++;
            if ({m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser, grant_id} !== prev_out) begin
                errors++;
                $display("FAIL stall_hold: got %h, expected held %h",
                         {m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser, grant_id}, prev_out);
            end
        end
        if (prev_gv && grant_valid) begin
            checks++;
            if (grant_id !== prev_gid) begin
                errors++;
                $display("FAIL grant_switch: got grant_id=%0d, expected %0d (no re-grant without IDLE)",
                         grant_id, prev_gid);
            end
        end
        if (grant_valid && !prev_gv) begin
            grant_log.push_back(int'(grant_id));
            gap_log.push_back(idle_run);
        end
        idle_run   = grant_valid ? 0 : idle_run + 1;
        prev_gv    = grant_valid && rst;
        prev_gid   = grant_id;
        prev_stall = m_tvalid && !m_tready && rst;
        prev_out   = {m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser, grant_id};
        acc        = s_tvalid & s_tready;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NUM_SRC; i++) drive_src(i, acc[i]);
        case (ready_mode)
            1:       m_tready = (cyc % 4 == 0) || (cyc % 4 == 3);
            2:       m_tready = 1'b0;
            default: m_tready = 1'b1;
        endcase
    endtask

    function automatic bit all_done();
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_q[i].size() != 0) return 1'b0;
        end
        return (s_tvalid == '0) && (sb.size() == 0) && !grant_valid;
    endfunction

    task automatic run_until_done(input string name);
        int n;
        n = 0;
        do begin
            step_cycle();
            n++;
        end while (!all_done() && n < 300);
        checks++;
        if (!all_done()) begin
            errors++;
            $display("FAIL %s_timeout: got %0d beats still expected after %0d cycles, expected 0",
                     name, sb.size(), n);
        end
    endtask

    task automatic start_test();
        grant_log.delete();
        gap_log.delete();
        trunc_cnt = 0;
        exp_trunc = 0;
    endtask

    task automatic check_grants(input string name, input int exp_ids[$]);
        checks++;
        if (grant_log.size() != exp_ids.size()) begin
            errors++;
            $display("FAIL %s_grant_count: got %0d grants, expected %0d", name, grant_log.size(), exp_ids.size());
        end else begin
            for (int k = 0; k < exp_ids.size(); k++) begin
                checks++;
                if (grant_log[k] != exp_ids[k]) begin
                    errors++;
                    $display("FAIL %s_grant_order[%0d]: got %0d, expected %0d", name, k, grant_log[k], exp_ids[k]);
                end
            end
        end
        checks++;
        if (trunc_cnt != exp_trunc) begin
            errors++;
            $display("FAIL %s_trunc_count: got %0d pulses, expected %0d", name, trunc_cnt, exp_trunc);
        end
    endtask

    task automatic test_reset();
        rst      = 1'b0;
        s_tvalid = '1;
        m_tready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({grant_valid, trunc_err, m_tvalid, s_tready, grant_id} !== '0) begin
            errors++;
            $display("FAIL reset_state: got grant_valid=%b trunc_err=%b m_tvalid=%b s_tready=%b grant_id=%0d, expected all 0",
                     grant_valid, trunc_err, m_tvalid, s_tready, grant_id);
        end
        @(posedge clk);
        #1;
        s_tvalid = '0;
        rst      = 1'b1;
    endtask

    task automatic test_round_robin();
        start_test();
        ready_mode = 0;
        gaps_on    = 1'b0;
        add_pkt(0, 2, 1'b0);
        add_pkt(1, 2, 1'b0);
        add_pkt(2, 2, 1'b0);
        add_pkt(3, 2, 1'b0);
        add_pkt(0, 2, 1'b0);
        run_until_done("round_robin");
        check_grants("round_robin", '{0, 1, 2, 3, 0});
        for (int k = 1; k < gap_log.size(); k++) begin
            checks++;
            if (gap_log[k] != 1) begin
                errors++;
                $display("FAIL rr_bubble[%0d]: got %0d idle cycles, expected 1", k, gap_log[k]);
            end
        end
    endtask

    task automatic test_truncation();
        start_test();
        add_pkt(2, 6, 1'b0);
        run_until_done("truncation");
        check_grants("truncation", '{2});
    endtask

    task automatic test_exact_max();
        start_test();
        gaps_on = 1'b1;
        add_pkt(1, MAX_BEATS, 1'b0);
        run_until_done("exact_max");
        check_grants("exact_max", '{1});
    endtask

    task automatic test_stall();
        int hold_start;
        start_test();
        hold_start = hold_cnt;
        ready_mode = 1;
        gaps_on    = 1'b1;
        add_pkt(3, 3, 1'b0);
        add_pkt(0, 3, 1'b0);
        run_until_done("stall");
        check_grants("stall", '{3, 0});
        checks++;
        if (hold_cnt == hold_start) begin
            errors++;
            $display("FAIL stall_coverage: got 0 stalled cycles, expected at least 1");
        end
        ready_mode = 0;
        gaps_on    = 1'b0;
    endtask

    task automatic test_user_err();
        start_test();
        add_pkt(3, 2, 1'b1);
        run_until_done("user_err");
        check_grants("user_err", '{3});
    endtask

    task automatic test_reset_mid();
        int start_cnt;
        int n;
        start_test();
        start_cnt = out_cnt;
        add_pkt(1, 4, 1'b0);
        n = 0;
        while (out_cnt < start_cnt + 1 && n < 50) begin
            step_cycle();
            n++;
        end
        checks++;
        if (out_cnt < start_cnt + 1) begin
            errors++;
            $display("FAIL reset_mid_first_beat: got %0d beats, expected 1", out_cnt - start_cnt);
        end
        rst        = 1'b0;
        ready_mode = 2;
        m_tready   = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) src_q[i].delete();
        sb.delete();
        step_cycle();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({grant_valid, trunc_err, m_tvalid, s_tready, grant_id} !== '0) begin
            errors++;
            $display("FAIL reset_mid_idle: got grant_valid=%b trunc_err=%b m_tvalid=%b s_tready=%b grant_id=%0d, expected all 0",
                     grant_valid, trunc_err, m_tvalid, s_tready, grant_id);
        end
        start_test();
        ready_mode = 0;
        add_pkt(0, 2, 1'b0);
        add_pkt(2, 2, 1'b0);
        run_until_done("reset_mid");
        check_grants("reset_mid", '{0, 2});
    endtask

    initial begin
        rst      = 1'b0;
        s_tvalid = '0;
        s_tlast  = '0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tuser  = '0;
        m_tready = 1'b1;
        test_reset();
        test_round_robin();
        test_truncation();
        test_exact_max();
        test_stall();
        test_user_err();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
